// File: rtl/output_stream_tx.sv
// output_stream_tx: buffers the result matrix Y written by the compute core,
// then streams it out in row-major order on an AXI-Stream master port.
// Data path: single-port result buffer -> registered read -> 2-entry skid -> AXIS.
module output_stream_tx #(
  parameter int OUTW = 32,
  parameter int R    = 9,
  parameter int C    = 8,
  parameter int MAXK = 4,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int Y_ADDR_BITS = $clog2(R * C)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OUTW-1:0]        Y_wr_data,
  input  logic [Y_ADDR_BITS-1:0] Y_wr_addr,
  input  logic                   Y_wr_en,
  input  logic [K_BITS-1:0]      K,
  input  logic                   compute_done,
  output logic                   output_ready,
  output logic                   output_sent,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  output logic                   AXIS_TLAST,
  input  logic                   AXIS_TREADY
);

  localparam int DEPTH = R * C;
  localparam int CW    = Y_ADDR_BITS + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t state_q, state_d;

  logic [OUTW-1:0] mem [DEPTH];
  logic [OUTW-1:0] rd_data_q;
  logic            rd_vld_q;
  logic            rd_last_q;

  logic [CW-1:0]   n_q;
  logic [CW-1:0]   rd_cnt_q;
  logic [CW-1:0]   beat_q;

  logic [OUTW-1:0] head_data_q, tail_data_q;
  logic            head_last_q, tail_last_q;
  logic            head_vld_q, tail_vld_q;

  logic [K_BITS-1:0] k_eff;
  logic [CW-1:0]     n_calc;
  logic [CW-1:0]     n_m1;
  logic [1:0]        fill_lvl;
  logic              wr_ok, start, pop, room, rd_issue, last_beat;

  // K==0 is treated as a 1x1 kernel
  assign k_eff  = (K == '0) ? K_BITS'(1) : K;
  assign n_calc = CW'((CW'(R + 1) - CW'(k_eff)) * (CW'(C + 1) - CW'(k_eff)));
  assign n_m1   = n_q - CW'(1);

  assign wr_ok = (state_q == S_IDLE) && Y_wr_en;
  assign start = (state_q == S_IDLE) && compute_done;
  assign pop   = head_vld_q && AXIS_TREADY;

  // Entries held or already in flight; a new read may only issue if its data
  // will find a free skid slot one cycle later (counting a pop happening now).
  assign fill_lvl = {1'b0, head_vld_q} + {1'b0, tail_vld_q} + {1'b0, rd_vld_q};
  assign room     = (fill_lvl <= 2'd1) || ((fill_lvl == 2'd2) && pop);
  assign rd_issue = (state_q == S_STREAM) && (rd_cnt_q < n_q) && room;

  assign last_beat = (state_q == S_STREAM) && pop && (beat_q == n_m1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (compute_done) state_d = S_STREAM;
      S_STREAM: if (last_beat)    state_d = S_DONE;
      S_DONE:                     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    output_ready = (state_q == S_IDLE);
    output_sent  = (state_q == S_DONE);
  end

  // Result buffer write port, open only while idle
  always_ff @(posedge clk) begin
    if (wr_ok) mem[Y_wr_addr] <= Y_wr_data;
  end

  // Result buffer registered read port
  always_ff @(posedge clk) begin
    if (rd_issue) rd_data_q <= mem[rd_cnt_q[Y_ADDR_BITS-1:0]];
  end

  // Counters, read pipeline tags and the 2-entry output skid
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q         <= '0;
      rd_cnt_q    <= '0;
      beat_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      head_vld_q  <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
      tail_vld_q  <= 1'b0;
    end else begin
      rd_vld_q  <= rd_issue;
      rd_last_q <= rd_issue && (rd_cnt_q == n_m1);

      if (start) begin
        n_q      <= n_calc;
        rd_cnt_q <= '0;
        beat_q   <= '0;
      end else begin
        if (rd_issue) rd_cnt_q <= rd_cnt_q + CW'(1);
        if (pop && (beat_q != n_m1)) beat_q <= beat_q + CW'(1);
      end

      if (state_q != S_STREAM) begin
        head_vld_q <= 1'b0;
        tail_vld_q <= 1'b0;
      end else if (pop) begin
        if (tail_vld_q) begin
          head_data_q <= tail_data_q;
          head_last_q <= tail_last_q;
          tail_vld_q  <= rd_vld_q;
          if (rd_vld_q) begin
            tail_data_q <= rd_data_q;
            tail_last_q <= rd_last_q;
          end
        end else begin
          head_vld_q <= rd_vld_q;
          if (rd_vld_q) begin
            head_data_q <= rd_data_q;
            head_last_q <= rd_last_q;
          end
        end
      end else if (rd_vld_q) begin
        if (!head_vld_q) begin
          head_data_q <= rd_data_q;
          head_last_q <= rd_last_q;
          head_vld_q  <= 1'b1;
        end else begin
          tail_data_q <= rd_data_q;
          tail_last_q <= rd_last_q;
          tail_vld_q  <= 1'b1;
        end
      end
    end
  end

  assign AXIS_TDATA  = head_data_q;
  assign AXIS_TVALID = head_vld_q;
  assign AXIS_TLAST  = head_vld_q && head_last_q;

endmodule

// File: tb/tb_output_stream_tx.sv
// Bench for output_stream_tx: directed scenarios with randomized data and
// backpressure, checked against a simple array model of the result buffer.
module tb_output_stream_tx;

  localparam int OUTW = 32;
  localparam int R    = 9;
  localparam int C    = 8;
  localparam int MAXK = 4;
  localparam int KB   = $clog2(MAXK + 1);
  localparam int AB   = $clog2(R * C);

  logic            clk = 1'b0;
  logic            reset;
  logic [OUTW-1:0] Y_wr_data;
  logic [AB-1:0]   Y_wr_addr;
  logic            Y_wr_en;
  logic [KB-1:0]   K;
  logic            compute_done;
  logic            output_ready;
  logic            output_sent;
  logic [OUTW-1:0] AXIS_TDATA;
  logic            AXIS_TVALID;
  logic            AXIS_TLAST;
  logic            AXIS_TREADY;

  output_stream_tx #(.OUTW(OUTW), .R(R), .C(C), .MAXK(MAXK)) dut (
    .clk          (clk),
    .reset        (reset),
    .Y_wr_data    (Y_wr_data),
    .Y_wr_addr    (Y_wr_addr),
    .Y_wr_en      (Y_wr_en),
    .K            (K),
    .compute_done (compute_done),
    .output_ready (output_ready),
    .output_sent  (output_sent),
    .AXIS_TDATA   (AXIS_TDATA),
    .AXIS_TVALID  (AXIS_TVALID),
    .AXIS_TLAST   (AXIS_TLAST),
    .AXIS_TREADY  (AXIS_TREADY)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [OUTW-1:0] model [R*C];

  function automatic int n_of(input int k);
    int ke;
    ke = (k == 0) ? 1 : k;
    return (R - ke + 1) * (C - ke + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write n words (random or base+i); the last write shares its cycle with compute_done.
  task automatic fill_and_start(input int n, input bit rnd, input int base, input int k);
    for (int i = 0; i < n; i++) begin
      Y_wr_en   = 1'b1;
      Y_wr_addr = AB'(i);
      Y_wr_data = rnd ? OUTW'($urandom) : OUTW'(base + i);
      model[i]  = Y_wr_data;
      if (i == n - 1) begin
        K = KB'(k);
        compute_done = 1'b1;
      end
      @(negedge clk);
    end
    Y_wr_en = 1'b0;
    compute_done = 1'b0;
    chk("busy_after_start", {31'b0, output_ready}, 32'd0);
  endtask

  task automatic start_only(input int k);
    K = KB'(k);
    compute_done = 1'b1;
    @(negedge clk);
    compute_done = 1'b0;
    chk("busy_after_start", {31'b0, output_ready}, 32'd0);
  endtask

  // Follow one stream from the negedge after compute_done was sampled.
  task automatic stream(input int k, input bit rnd, input bit interfere, input int abort_after);
    int n, idx, cyc;
    logic pv, pr, pl;
    logic [OUTW-1:0] pd;
    n = n_of(k); idx = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
    while (idx < n && cyc < 3000) begin
      if (cyc < 2)  chk("latency_low", {31'b0, AXIS_TVALID}, 32'd0);
      if (cyc == 2) chk("latency_first", {31'b0, AXIS_TVALID}, 32'd1);
      chk("sent_low", {31'b0, output_sent}, 32'd0);
      if (AXIS_TVALID) begin
        if (pv && !pr) begin
          chk("stall_data", AXIS_TDATA, pd);
          chk("stall_last", {31'b0, AXIS_TLAST}, {31'b0, pl});
        end
        chk($sformatf("data[%0d]", idx), AXIS_TDATA, model[idx]);
        chk($sformatf("last[%0d]", idx), {31'b0, AXIS_TLAST}, (idx == n - 1) ? 32'd1 : 32'd0);
      end else if (pv) begin
        chk("valid_dropped", {31'b0, AXIS_TVALID}, 32'd1);
      end
      pv = AXIS_TVALID; pd = AXIS_TDATA; pl = AXIS_TLAST;
      Y_wr_en      = interfere && (cyc == 0 || cyc == 5);
      compute_done = interfere && (cyc == 0 || cyc == 5);
      Y_wr_addr    = '0;
      Y_wr_data    = 32'hDEAD;
      K            = KB'(1);
      pr = rnd ? 1'($urandom % 2) : 1'b1;
      AXIS_TREADY = pr;
      if (AXIS_TVALID && pr) begin
        $display("[TB] K=%0d beat %0d data=%h last=%0d", k, idx, AXIS_TDATA, AXIS_TLAST);
        idx++;
      end
      @(negedge clk);
      cyc++;
      Y_wr_en = 1'b0;
      compute_done = 1'b0;
      if (abort_after > 0 && idx == abort_after) begin
        reset = 1'b1;
        AXIS_TREADY = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_tvalid", {31'b0, AXIS_TVALID}, 32'd0);
        chk("abort_ready", {31'b0, output_ready}, 32'd1);
        return;
      end
    end
    chk("beats_seen", idx, n);
    chk("done_tvalid", {31'b0, AXIS_TVALID}, 32'd0);
    chk("sent_pulse", {31'b0, output_sent}, 32'd1);
    AXIS_TREADY = 1'b0;
    @(negedge clk);
    chk("sent_once", {31'b0, output_sent}, 32'd0);
    chk("ready_back", {31'b0, output_ready}, 32'd1);
    chk("idle_tvalid", {31'b0, AXIS_TVALID}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; Y_wr_data = '0; Y_wr_addr = '0; Y_wr_en = 1'b0;
    K = '0; compute_done = 1'b0; AXIS_TREADY = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_tvalid", {31'b0, AXIS_TVALID}, 32'd0);
    chk("rst_tlast", {31'b0, AXIS_TLAST}, 32'd0);
    chk("rst_tdata", AXIS_TDATA, 32'd0);
    chk("rst_ready", {31'b0, output_ready}, 32'd1);
    chk("rst_sent", {31'b0, output_sent}, 32'd0);
    @(negedge clk);

    // K=2, incrementing data, TREADY high
    fill_and_start(56, 1'b0, 32'h1000, 2);
    stream(2, 1'b0, 1'b0, 0);

    // K=4, random backpressure
    fill_and_start(30, 1'b0, 32'hA0, 4);
    stream(4, 1'b1, 1'b0, 0);

    // Writes and compute_done during streaming must be ignored
    start_only(4);
    stream(4, 1'b1, 1'b1, 0);
    repeat (4) begin
      @(negedge clk);
      chk("no_restart", {31'b0, AXIS_TVALID}, 32'd0);
      chk("still_idle", {31'b0, output_ready}, 32'd1);
    end

    // Abort a K=2 stream after 10 beats, then a fresh K=3 stream
    start_only(2);
    stream(2, 1'b0, 1'b0, 10);
    @(negedge clk);
    fill_and_start(42, 1'b1, 0, 3);
    stream(3, 1'b0, 1'b0, 0);

    // Back-to-back: K=3 then K=2 started in the first idle cycle
    fill_and_start(56, 1'b1, 0, 3);
    stream(3, 1'b1, 1'b0, 0);
    start_only(2);
    stream(2, 1'b1, 1'b0, 0);

    // K=0 behaves as K=1
    fill_and_start(72, 1'b1, 0, 0);
    stream(0, 1'b1, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
